// File: rtl/ps2_key_decoder_if.sv
// PS/2 receiver bus: keyboard line inputs and decoded key outputs.
// master = keyboard/stimulus side, slave = decoder side.
interface ps2_key_decoder_if #(
  parameter int NUM_KEYS = 2
);
  logic                k_clk;
  logic                k_dat;
  logic [7:0]          code;
  logic                code_valid;
  logic                code_ext;
  logic                code_break;
  logic [NUM_KEYS-1:0] key_state;
  logic                frame_err;

  modport master (
    output k_clk, k_dat,
    input  code, code_valid, code_ext, code_break, key_state, frame_err
  );

  modport slave (
    input  k_clk, k_dat,
    output code, code_valid, code_ext, code_break, key_state, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with E0/F0 prefix decoding and held-key bitmap.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make codes of held tracked keys.
module ps2_key_decoder #(
  parameter int                    SYNC_STAGES = 2,
  parameter int                    FILT_LEN    = 4,
  parameter int                    TIMEOUT_CYC = 50000,
  parameter int                    NUM_KEYS    = 2,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES   = {9'h172, 9'h175}
) (
  input logic               clk,
  input logic               reset,
  ps2_key_decoder_if.slave  bus
);

  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clkSync_q, datSync_q;
  logic                   filtClk_q, filtPrev_q;
  logic [FW-1:0]          filtCnt_q;
  logic                   syncClk, syncDat, edgePulse;

  state_t                 state_q, state_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          toCnt_q, toCnt_d;
  logic                   extPend_q, extPend_d, brkPend_q, brkPend_d;
  logic [7:0]             code_q, code_d;
  logic                   codeValid_q, codeValid_d, codeExt_q, codeExt_d;
  logic                   codeBreak_q, codeBreak_d, frameErr_q, frameErr_d;
  logic [NUM_KEYS-1:0]    keyState_q, keyState_d, keyMatch;
  logic                   repeatHit;

  // Line synchronisers preset high so an idle bus produces no edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync_q <= '1;
      datSync_q <= '1;
    end else begin
      clkSync_q <= {clkSync_q[SYNC_STAGES-2:0], bus.k_clk};
      datSync_q <= {datSync_q[SYNC_STAGES-2:0], bus.k_dat};
    end
  end

  assign syncClk = clkSync_q[SYNC_STAGES-1];
  assign syncDat = datSync_q[SYNC_STAGES-1];

  // Filtered clock only follows after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filtClk_q  <= 1'b1;
      filtPrev_q <= 1'b1;
      filtCnt_q  <= '0;
    end else begin
      filtPrev_q <= filtClk_q;
      if (syncClk == filtClk_q) begin
        filtCnt_q <= '0;
      end else if (filtCnt_q == FW'(FILT_LEN - 1)) begin
        filtClk_q <= syncClk;
        filtCnt_q <= '0;
      end else begin
        filtCnt_q <= filtCnt_q + FW'(1);
      end
    end
  end

  assign edgePulse = filtPrev_q & ~filtClk_q;

  always_comb begin
    keyMatch = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      keyMatch[i] = ({extPend_q, shift_q} == KEY_CODES[9*i +: 9]);
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign repeatHit = ~brkPend_q & (|(keyMatch & keyState_q));
`else
  assign repeatHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      toCnt_q     <= '0;
      extPend_q   <= 1'b0;
      brkPend_q   <= 1'b0;
      code_q      <= '0;
      codeValid_q <= 1'b0;
      codeExt_q   <= 1'b0;
      codeBreak_q <= 1'b0;
      keyState_q  <= '0;
      frameErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      toCnt_q     <= toCnt_d;
      extPend_q   <= extPend_d;
      brkPend_q   <= brkPend_d;
      code_q      <= code_d;
      codeValid_q <= codeValid_d;
      codeExt_q   <= codeExt_d;
      codeBreak_q <= codeBreak_d;
      keyState_q  <= keyState_d;
      frameErr_q  <= frameErr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    toCnt_d     = (state_q == IDLE || edgePulse) ? '0 : toCnt_q + TW'(1);
    extPend_d   = extPend_q;
    brkPend_d   = brkPend_q;
    code_d      = code_q;
    codeValid_d = 1'b0;
    codeExt_d   = codeExt_q;
    codeBreak_d = codeBreak_q;
    keyState_d  = keyState_q;
    frameErr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (edgePulse && !syncDat) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (edgePulse) begin
          shift_d  = {syncDat, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (edgePulse) begin
          parity_d = syncDat;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (edgePulse) begin
          state_d = IDLE;
          if (syncDat && (^{shift_q, parity_q})) begin
            if (shift_q == 8'hE0) begin
              extPend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brkPend_d = 1'b1;
            end else begin
              extPend_d = 1'b0;
              brkPend_d = 1'b0;
              if (!repeatHit) begin
                codeValid_d = 1'b1;
                code_d      = shift_q;
                codeExt_d   = extPend_q;
                codeBreak_d = brkPend_q;
                for (int i = 0; i < NUM_KEYS; i++) begin
                  if (keyMatch[i]) keyState_d[i] = ~brkPend_q;
                end
              end
            end
          end else begin
            frameErr_d = 1'b1;
            extPend_d  = 1'b0;
            brkPend_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog: a stalled frame is abandoned along with any pending prefixes.
    if (state_q != IDLE && !edgePulse && toCnt_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d    = IDLE;
      toCnt_d    = '0;
      frameErr_d = 1'b1;
      extPend_d  = 1'b0;
      brkPend_d  = 1'b0;
    end
  end

  assign bus.code       = code_q;
  assign bus.code_valid = codeValid_q;
  assign bus.code_ext   = codeExt_q;
  assign bus.code_break = codeBreak_q;
  assign bus.key_state  = keyState_q;
  assign bus.frame_err  = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames, expected events queued, monitor compares.
module tb_ps2_key_decoder;

  localparam int HALF = 10;
  localparam int GAP  = 30;
  localparam int TO   = 300;

  typedef struct packed {
    logic       isErr;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [1:0] keys;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t expQ[$];

  ps2_key_decoder_if #(.NUM_KEYS(2)) bus ();

  ps2_key_decoder #(
    .SYNC_STAGES (2),
    .FILT_LEN    (4),
    .TIMEOUT_CYC (TO),
    .NUM_KEYS    (2),
    .KEY_CODES   ({9'h172, 9'h175})
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expectCode(input logic [7:0] c, input logic e, input logic b, input logic [1:0] k);
    exp_t x;
    x.isErr = 1'b0; x.code = c; x.ext = e; x.brk = b; x.keys = k;
    expQ.push_back(x);
  endtask

  task automatic expectErr();
    exp_t x;
    x = '0;
    x.isErr = 1'b1;
    expQ.push_back(x);
  endtask

  task automatic sendBit(input logic b, input bit glitch);
    bus.k_dat = b;
    if (glitch) begin
      repeat (3) @(negedge clk);
      bus.k_clk = 1'b0;
      repeat (2) @(negedge clk);
      bus.k_clk = 1'b1;
      repeat (HALF - 5) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    bus.k_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.k_clk = 1'b1;
  endtask

  // Sends the first nBits bits of a frame (11 = complete frame followed by an idle gap).
  task automatic applyStimulus(input logic [7:0] d, input bit badPar, input logic stopVal,
                               input int glitchBit, input int nBits);
    logic [10:0] fr;
    fr = {stopVal, (~^d) ^ badPar, d, 1'b0};
    for (int i = 0; i < nBits; i++) sendBit(fr[i], i == glitchBit);
    bus.k_dat = 1'b1;
    if (nBits == 11) repeat (GAP) @(negedge clk);
  endtask

  task automatic sendGood(input logic [7:0] d);
    applyStimulus(d, 1'b0, 1'b1, -1, 11);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && (bus.code_valid || bus.frame_err)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_strobe", {bus.code_valid, bus.frame_err, bus.code}, 32'h0);
        end else begin
          x = expQ.pop_front();
          checkOutput("strobe_kind", {bus.code_valid, bus.frame_err}, x.isErr ? 2'b01 : 2'b10);
          if (!x.isErr) begin
            checkOutput("code", bus.code, x.code);
            checkOutput("code_ext", bus.code_ext, x.ext);
            checkOutput("code_break", bus.code_break, x.brk);
            checkOutput("key_state", bus.key_state, x.keys);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.k_clk = 1'b1;
    bus.k_dat = 1'b1;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_code", bus.code, 8'h00);
    checkOutput("rst_code_valid", bus.code_valid, 1'b0);
    checkOutput("rst_code_ext", bus.code_ext, 1'b0);
    checkOutput("rst_code_break", bus.code_break, 1'b0);
    checkOutput("rst_key_state", bus.key_state, 2'b00);
    checkOutput("rst_frame_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    expectCode(8'h75, 1'b1, 1'b0, 2'b01);
    sendGood(8'hE0); sendGood(8'h75);
    expectCode(8'h75, 1'b1, 1'b1, 2'b00);
    sendGood(8'hE0); sendGood(8'hF0); sendGood(8'h75);

    expectCode(8'h1C, 1'b0, 1'b0, 2'b00);
    sendGood(8'h1C);
    expectErr();
    applyStimulus(8'h1C, 1'b1, 1'b1, -1, 11);
    expectErr();
    applyStimulus(8'h1C, 1'b0, 1'b0, -1, 11);

    // Pending E0 must be dropped by the timeout.
    sendGood(8'hE0);
    expectErr();
    applyStimulus(8'h55, 1'b0, 1'b1, -1, 4);
    repeat (TO + 100) @(negedge clk);
    expectCode(8'h29, 1'b0, 1'b0, 2'b00);
    sendGood(8'h29);

    bus.k_clk = 1'b0;
    repeat (2) @(negedge clk);
    bus.k_clk = 1'b1;
    repeat (20) @(negedge clk);
    expectCode(8'h1B, 1'b0, 1'b0, 2'b00);
    applyStimulus(8'h1B, 1'b0, 1'b1, 4, 11);

`ifdef PS2_TYPEMATIC_FILTER_EN
    expectCode(8'h72, 1'b1, 1'b0, 2'b10);
`else
    for (int i = 0; i < 3; i++) expectCode(8'h72, 1'b1, 1'b0, 2'b10);
`endif
    for (int i = 0; i < 3; i++) begin
      sendGood(8'hE0); sendGood(8'h72);
    end

    expectCode(8'h72, 1'b1, 1'b1, 2'b00);
    sendGood(8'hF0); sendGood(8'hE0); sendGood(8'h72);
    expectCode(8'h75, 1'b1, 1'b0, 2'b01);
    sendGood(8'hE0); sendGood(8'hE0); sendGood(8'h75);

    applyStimulus(8'h3A, 1'b0, 1'b1, -1, 6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_code", bus.code, 8'h00);
    checkOutput("midrst_code_valid", bus.code_valid, 1'b0);
    checkOutput("midrst_code_ext", bus.code_ext, 1'b0);
    checkOutput("midrst_code_break", bus.code_break, 1'b0);
    checkOutput("midrst_key_state", bus.key_state, 2'b00);
    checkOutput("midrst_frame_err", bus.frame_err, 1'b0);
    repeat (10) @(negedge clk);
    expectCode(8'h75, 1'b1, 1'b0, 2'b01);
    sendGood(8'hE0); sendGood(8'h75);

    repeat (50) @(negedge clk);
    checkOutput("events_outstanding", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
